fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 5-stage pipeline.
- Owns the PC register and issues single-outstanding requests to inst_mem, which has variable latency.
- Presents fetched instruction, PC and PC+4 to decode. Honours decode stall; applies branch/jal/jalr redirects from execute with flush.
- Replaces free-running PC+4 update with handshake-driven sequencing.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0013, value driven on if_inst when no valid instruction (addi x0,x0,0).

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
imem_req  out  1  one-cycle fetch request pulse (combinational from state/inputs).
imem_addr  out  32  fetch address; equals pc register.
imem_rvalid  in  1  response strobe; arrives >=1 cycle after imem_req.
imem_rdata  in  32  instruction, valid with imem_rvalid.
redir_valid  in  1  execute redirect strobe.
redir_type  in  2  01 branch taken, 10 jal, 11 jalr, 00 ignored.
redir_pc  in  32  PC of redirecting instruction.
redir_imm  in  32  sign-extended immediate.
redir_rs1  in  32  rs1 value (jalr only).
id_stall  in  1  decode cannot accept; hold if_* outputs.
if_valid  out  1  if_* outputs hold a valid instruction.
if_inst  out  32  fetched instruction.
if_pc  out  32  address of if_inst.
if_pc4  out  32  if_pc + 4.
misalign  out  1  one-cycle pulse: redirect target not word-aligned.

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC, state=ISSUE.
  - if_valid=0, if_inst=NOP_INST, if_pc=0, if_pc4=4.
  - misalign=0, skid buffer empty.
  - Reset overrides everything, including an outstanding request; any rvalid arriving after reset for a pre-reset request is ignored (state ISSUE/WAIT treats it per rules below only if a request was issued post-reset).
- Target calculation (32-bit, mod 2^32): branch/jal target = redir_pc+redir_imm; jalr target = (redir_rs1+redir_imm) & ~1.
- Effective redirect: redir_valid=1 and redir_type!=00.
- Misaligned redirect: target[1:0]!=0.
  - misalign pulses 1 cycle and if_valid clears.
  - pc is unchanged; state goes to HALT. HALT is left only by rst.
- Redirect priority: redirect beats id_stall and imem_rvalid in the same cycle.
  - if_valid<=0 (flush), skid cleared, pc<=target.
- Decode consumes output when if_valid=1 and id_stall=0. The output slot is free when if_valid=0 or it is consumed this cycle.
- States:
  - ISSUE: imem_req = slot_free && !redirect. When asserted, go WAIT. Redirect: stay ISSUE with new pc. Otherwise stay.
  - WAIT, request outstanding:
    - Redirect without rvalid -> DROP.
    - Redirect with rvalid -> discard data, go ISSUE.
    - rvalid and slot free -> load if_inst/if_pc=pc/if_pc4=pc+4, if_valid<=1, pc<=pc+4, go ISSUE.
    - rvalid and slot busy (stalled) -> store data+pc in skid, pc<=pc+4, go HOLD.
  - HOLD: when slot free, move skid to if_*, if_valid<=1, go ISSUE. Redirect -> discard skid, go ISSUE.
  - DROP: discard next rvalid, go ISSUE. Redirect in DROP updates pc and stays DROP. Redirect coincident with rvalid updates pc and goes ISSUE.
  - HALT: imem_req=0. if_valid drains normally when consumed.
- Stall rules:
  - While if_valid=1 and id_stall=1, if_* outputs are stable.
  - Only one request outstanding ever.
- PC wrap: 32'hFFFF_FFFC + 4 = 0, no flag.
- Peak throughput: one instruction per 2 cycles with 1-cycle memory latency.

Test Plan:
- Reset, 1-cycle memory returning addr-based data, no stall:
  - imem_addr sequence 0,4,8,C.
  - if_pc 0,4,8 with if_pc4 4,8,C.
  - if_valid first high 2 cycles after reset release.
- id_stall held 5 cycles after if_pc=4 shown, with response for 8 arriving:
  - if_* frozen at pc 4 and no new imem_req.
  - On release, if_pc=8 next cycle, then imem_req addr C.
- Branch, redir_pc=0x10, imm=0x20, while WAIT and rvalid 2 cycles later:
  - Stale response dropped and if_valid=0.
  - Next imem_addr=0x30.
- jalr, rs1=0x101, imm=0x4 -> next imem_addr=0x104. Same-cycle redirect plus id_stall -> flush wins, if_valid=0.
- jal, redir_pc=0x8, imm=0x6:
  - misalign pulse 1 cycle, imem_req stays 0 forever.
  - rst then restarts fetch at RESET_PC.
- pc=0xFFFF_FFFC fetch -> if_pc4=0, next imem_addr=0. Also assert rst mid-WAIT -> pc=RESET_PC, if_valid=0 next cycle.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus bundle.
// Groups the instruction-memory handshake, the execute redirect inputs and the
// decode-facing outputs of fetch_ctrl.
//   master : fetch_ctrl side (drives imem_req/imem_addr, if_*, misalign)
//   slave  : environment side (memory, execute, decode)
interface fetch_ctrl_if;
  // instruction memory
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  // execute redirect
  logic        redir_valid;
  logic [1:0]  redir_type;
  logic [31:0] redir_pc;
  logic [31:0] redir_imm;
  logic [31:0] redir_rs1;
  // decode
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        misalign;

  modport master (
    output imem_req, imem_addr, if_valid, if_inst, if_pc, if_pc4, misalign,
    input  imem_rvalid, imem_rdata, redir_valid, redir_type, redir_pc, redir_imm,
           redir_rs1, id_stall
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_inst, if_pc, if_pc4, misalign,
    output imem_rvalid, imem_rdata, redir_valid, redir_type, redir_pc, redir_imm,
           redir_rs1, id_stall
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer.
// Owns the PC, issues single-outstanding requests to a variable-latency
// instruction memory and presents instruction, PC and PC+4 to decode. Decode
// stalls hold the outputs; execute redirects flush and retarget the PC, and a
// misaligned redirect target halts fetch until reset.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - fetch_ctrl_if.master (imem handshake, redirect inputs, if_* outputs)
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input logic   clk,
  input logic   rst,
  fetch_ctrl_if.master bus
);

  typedef enum logic [2:0] {StIssue, StWait, StHold, StDrop, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc4_q, if_pc4_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        misalign_q, misalign_d;
  logic        imem_req;

  logic        redirect;
  logic        redir_ok;
  logic        redir_bad;
  logic [31:0] jalr_sum;
  logic [31:0] target;
  logic        consume;
  logic        slot_free;
  logic [31:0] pc_plus4;
  logic [31:0] skid_pc4;

  // Redirects are ignored once halted; only reset leaves HALT.
  assign redirect  = bus.redir_valid && (bus.redir_type != 2'b00) && (state_q != StHalt);
  assign jalr_sum  = bus.redir_rs1 + bus.redir_imm;
  assign target    = (bus.redir_type == 2'b11) ? (jalr_sum & 32'hFFFF_FFFE)
                                               : (bus.redir_pc + bus.redir_imm);
  assign redir_bad = redirect && (target[1:0] != 2'b00);
  assign redir_ok  = redirect && !redir_bad;

  assign consume   = if_valid_q && !bus.id_stall;
  assign slot_free = !if_valid_q || consume;
  assign pc_plus4  = pc_q + 32'd4;
  assign skid_pc4  = skid_pc_q + 32'd4;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIssue;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (redir_bad) begin
      state_d = StHalt;
    end else begin
      case (state_q)
        StIssue: begin
          if (!redir_ok && slot_free) state_d = StWait;
        end
        StWait: begin
          if (redir_ok) begin
            // A redirect racing the response discards it; otherwise the
            // response is still in flight and must be dropped on arrival.
            state_d = bus.imem_rvalid ? StIssue : StDrop;
          end else if (bus.imem_rvalid) begin
            state_d = slot_free ? StIssue : StHold;
          end
        end
        StHold: begin
          if (redir_ok || slot_free) state_d = StIssue;
        end
        StDrop: begin
          if (bus.imem_rvalid) state_d = StIssue;
        end
        StHalt:  state_d = StHalt;
        default: state_d = StIssue;
      endcase
    end
  end

  // Outputs and datapath next values
  always_comb begin
    imem_req    = 1'b0;
    pc_d        = pc_q;
    if_valid_d  = if_valid_q && !consume;
    if_inst_d   = if_inst_q;
    if_pc_d     = if_pc_q;
    if_pc4_d    = if_pc4_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    misalign_d  = 1'b0;

    if (redirect) begin
      if_valid_d  = 1'b0;
      skid_inst_d = NOP_INST;
      skid_pc_d   = 32'h0;
      if (redir_bad) begin
        misalign_d = 1'b1;
      end else begin
        pc_d = target;
      end
    end else begin
      case (state_q)
        StIssue: imem_req = slot_free;
        StWait: begin
          if (bus.imem_rvalid) begin
            pc_d = pc_plus4;
            if (slot_free) begin
              if_valid_d = 1'b1;
              if_inst_d  = bus.imem_rdata;
              if_pc_d    = pc_q;
              if_pc4_d   = pc_plus4;
            end else begin
              skid_inst_d = bus.imem_rdata;
              skid_pc_d   = pc_q;
            end
          end
        end
        StHold: begin
          if (slot_free) begin
            if_valid_d = 1'b1;
            if_inst_d  = skid_inst_q;
            if_pc_d    = skid_pc_q;
            if_pc4_d   = skid_pc4;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      if_valid_q  <= 1'b0;
      if_inst_q   <= NOP_INST;
      if_pc_q     <= 32'h0;
      if_pc4_q    <= 32'h4;
      skid_inst_q <= NOP_INST;
      skid_pc_q   <= 32'h0;
      misalign_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      if_valid_q  <= if_valid_d;
      if_inst_q   <= if_inst_d;
      if_pc_q     <= if_pc_d;
      if_pc4_q    <= if_pc4_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      misalign_q  <= misalign_d;
    end
  end

  assign bus.imem_req  = imem_req;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_inst   = if_inst_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_pc4    = if_pc4_q;
  assign bus.misalign  = misalign_q;

endmodule
